heard_packer: RTL and testbench



---
 rtl/heard_packer_pkg.sv | 18 +
 rtl/heard_packer_timeout.sv | 32 +++
 rtl/heard_packer.sv | 99 +++++++++
 tb/tb_heard_packer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/heard_packer_pkg.sv
// Shared types for the heard packer: message header layout and packer FSM states.
// Imported by the packer core and its idle-timeout helper.
package heard_packer_pkg;

   localparam int DATA_WIDTH_DEF   = 32;
   localparam int HEADER_WIDTH_DEF = 16;

   typedef struct packed {
      logic [7:0] method;
      logic [7:0] count;
   } header_t;

   typedef enum logic {
      FILL = 1'b0,
      SEND = 1'b1
   } state_t;

endpackage

// File: rtl/heard_packer_timeout.sv
// Idle counter for the packer: counts cycles without a new word while a partial
// message is buffered, and flags when the partial message should be flushed.
module packer_timeout #(
   parameter int TIMEOUT = 16
) (
   input  logic CLK,
   input  logic nRST,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int IDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   logic [IDW-1:0] idle;

   // NOTE: sequential state is only ever assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         idle <= '0;
      end else if (clr) begin
         idle <= '0;
      end else if (en && (idle != '1)) begin
         idle <= idle + IDW'(1);
      end
   end

   // Fires on the idle cycle that brings the count to TIMEOUT-1, so the message
   // goes out exactly TIMEOUT cycles after the last accepted word.
   assign expire = en && (TIMEOUT != 0) && ((int'(idle) + 1) >= (TIMEOUT - 1));

endmodule

// File: rtl/heard_packer.sv
// Packs 32-bit indication words into {header, payload} pipe messages, sending a
// full message after WORDS words or a partial one after an idle timeout.
module heard_packer
   import heard_packer_pkg::*;
#(
   parameter int         DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int         WORDS        = 4,
   parameter int         HEADER_WIDTH = HEADER_WIDTH_DEF,
   parameter logic [7:0] METHOD_ID    = 8'd0,
   parameter int         TIMEOUT      = 16
) (
   input  logic                                     CLK,
   input  logic                                     nRST,
   input  logic                                     in_enq__ENA,
   input  logic [DATA_WIDTH-1:0]                    in_enq_v,
   output logic                                     in_enq__RDY,
   output logic                                     out_enq__ENA,
   output logic [HEADER_WIDTH+DATA_WIDTH*WORDS-1:0] out_enq_v,
   input  logic                                     out_enq__RDY
);

   localparam int CW = $clog2(WORDS + 1);
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

   state_t                             state, state_n;
   logic [CW-1:0]                      count, count_n;
   logic [WORDS-1:0][DATA_WIDTH-1:0]   buffer, buffer_n;
   logic                               in_rdy, out_ena, in_fire;
   logic                               idle_clr, idle_en, expire;
   header_t                            hdr;

   assign in_enq__RDY  = nRST & in_rdy;
   assign out_enq__ENA = nRST & out_ena;
   assign in_fire      = in_enq__ENA & in_enq__RDY;

   assign idle_clr = in_fire || (state == SEND);
   assign idle_en  = (state == FILL) && (count != '0) && !in_fire;

   packer_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .CLK    (CLK),
      .nRST   (nRST),
      .clr    (idle_clr),
      .en     (idle_en),
      .expire (expire)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= FILL;
         count  <= '0;
         buffer <= '0;
      end else begin
         state  <= state_n;
         count  <= count_n;
         buffer <= buffer_n;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_n  = state;
      count_n  = count;
      buffer_n = buffer;
      in_rdy   = 1'b0;
      out_ena  = 1'b0;
      unique case (state)
         FILL: begin
            in_rdy = 1'b1;
            if (in_enq__ENA) begin
               buffer_n[count[IW-1:0]] = in_enq_v;
               count_n = count + CW'(1);
               if (count_n == CW'(WORDS)) state_n = SEND;
            end else if (expire) begin
               state_n = SEND;
            end
         end
         SEND: begin
            in_rdy  = out_enq__RDY;
            out_ena = out_enq__RDY;
            if (out_enq__RDY) begin
               // The sent buffer is cleared so a partial message never carries stale words.
               buffer_n = '0;
               count_n  = '0;
               state_n  = FILL;
               if (in_enq__ENA) begin
                  buffer_n[0] = in_enq_v;
                  count_n     = CW'(1);
                  if (count_n == CW'(WORDS)) state_n = SEND;
               end
            end
         end
         default: state_n = FILL;
      endcase
   end

   assign hdr       = '{method: METHOD_ID, count: 8'(count)};
   assign out_enq_v = (state == SEND) ? {hdr, buffer} : '0;

endmodule

// File: tb/tb_heard_packer.sv
// Self-checking bench for heard_packer: directed scenarios plus a randomized
// stream checked against a queue-based message model.
module tb_heard_packer;

   typedef logic [143:0] msg_t;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        in_ena = 1'b0;
   logic [31:0] in_v = '0;
   logic        in_rdy, out_ena;
   msg_t        out_v;
   logic        out_rdy = 1'b1;

   logic        z_in_ena = 1'b0;
   logic [31:0] z_in_v = '0;
   logic        z_in_rdy, z_out_ena;
   msg_t        z_out_v;
   logic        z_out_rdy = 1'b1;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          z_msgs = 0;
   msg_t        z_last = '0;
   bit          rand_rdy = 1'b0;
   logic [31:0] acc_q[$];
   msg_t        msg_q[$];
   int          msg_cyc_q[$];

   always #5 CLK = ~CLK;

   heard_packer #(.TIMEOUT(16)) dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .in_enq__ENA  (in_ena),
      .in_enq_v     (in_v),
      .in_enq__RDY  (in_rdy),
      .out_enq__ENA (out_ena),
      .out_enq_v    (out_v),
      .out_enq__RDY (out_rdy)
   );

   heard_packer #(.TIMEOUT(0)) dut_nt (
      .CLK          (CLK),
      .nRST         (nRST),
      .in_enq__ENA  (z_in_ena),
      .in_enq_v     (z_in_v),
      .in_enq__RDY  (z_in_rdy),
      .out_enq__ENA (z_out_ena),
      .out_enq_v    (z_out_v),
      .out_enq__RDY (z_out_rdy)
   );

   always @(posedge CLK) cyc++;

   always @(posedge CLK) begin
      if (rand_rdy) begin
         #1;
         out_rdy = 1'($urandom_range(0, 1));
      end
   end

   always @(negedge CLK) begin
      if (in_ena && in_rdy) begin
         acc_q.push_back(in_v);
         acc_cyc = cyc;
      end
      if (out_ena) begin
         msg_q.push_back(out_v);
         msg_cyc_q.push_back(cyc);
      end
      if (z_out_ena) begin
         z_msgs++;
         z_last = z_out_v;
      end
   end

   function automatic msg_t make_msg(input logic [31:0] ws[$]);
      msg_t m = '0;
      for (int i = 0; i < ws.size(); i++) m[32*i +: 32] = ws[i];
      m[135:128] = 8'(ws.size());
      return m;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic clear_logs();
      acc_q.delete();
      msg_q.delete();
      msg_cyc_q.delete();
   endtask

   task automatic send_word(input logic [31:0] w);
      int n = 0;
      in_ena = 1'b1;
      in_v   = w;
      @(negedge CLK);
      while (!in_rdy && n < 200) begin
         @(negedge CLK);
         n++;
      end
      n_cmp++;
      if (in_rdy !== 1'b1) begin
         n_err++;
         $display("FAIL send_word_wait: in RDY never rose for word %h", w);
      end
      @(posedge CLK);
      #1;
      in_ena = 1'b0;
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      #2;
      n_cmp++;
      if (in_rdy !== 1'b0 || out_ena !== 1'b0 || out_v !== '0 || z_in_rdy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs: in_rdy=%b out_ena=%b out_v=%h, required 0/0/0", in_rdy, out_ena, out_v);
      end
      tick(2);
      nRST = 1'b1;
      @(negedge CLK);
      n_cmp++;
      if (in_rdy !== 1'b1 || out_ena !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: in_rdy=%b out_ena=%b, required 1/0", in_rdy, out_ena);
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic test_full();
      msg_t exp = {16'h0004, 128'h44444444_33333333_22222222_11111111};
      out_rdy = 1'b1;
      clear_logs();
      send_word(32'h11111111);
      send_word(32'h22222222);
      send_word(32'h33333333);
      send_word(32'h44444444);
      tick(8);
      n_cmp++;
      if (msg_q.size() !== 1) begin
         n_err++;
         $display("FAIL full_msg_count: got %0d messages, required 1", msg_q.size());
      end else begin
         n_cmp++;
         if (msg_q[0] !== exp) begin
            n_err++;
            $display("FAIL full_msg_value: got %h required %h", msg_q[0], exp);
         end
         n_cmp++;
         if (msg_cyc_q[0] !== acc_cyc + 1) begin
            n_err++;
            $display("FAIL full_msg_latency: ENA at cycle %0d, required %0d", msg_cyc_q[0], acc_cyc + 1);
         end
      end
   endtask

   task automatic test_timeout();
      msg_t exp = {16'h0002, 64'h0, 32'h0000000B, 32'h0000000A};
      clear_logs();
      send_word(32'h0000000A);
      send_word(32'h0000000B);
      tick(30);
      n_cmp++;
      if (msg_q.size() !== 1) begin
         n_err++;
         $display("FAIL timeout_count: got %0d messages, required 1", msg_q.size());
      end else begin
         n_cmp++;
         if (msg_q[0] !== exp) begin
            n_err++;
            $display("FAIL timeout_value: got %h required %h", msg_q[0], exp);
         end
         n_cmp++;
         if (msg_cyc_q[0] !== acc_cyc + 16) begin
            n_err++;
            $display("FAIL timeout_latency: flush at cycle %0d, required %0d", msg_cyc_q[0], acc_cyc + 16);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] ws[$];
      logic [31:0] ws2[$];
      msg_t        exp, exp2;
      int          bad = 0;
      clear_logs();
      out_rdy = 1'b0;
      for (int i = 0; i < 4; i++) ws.push_back($urandom);
      for (int i = 0; i < 4; i++) ws2.push_back($urandom);
      exp  = make_msg(ws);
      exp2 = make_msg(ws2);
      for (int i = 0; i < 4; i++) send_word(ws[i]);
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (in_rdy !== 1'b0 || out_ena !== 1'b0 || out_v !== exp) begin
            bad++;
            $display("FAIL stall_hold: cycle %0d in_rdy=%b out_ena=%b out_v=%h, required 0/0/%h", i, in_rdy, out_ena, out_v, exp);
         end
      end
      n_cmp++;
      if (bad != 0) n_err++;
      @(posedge CLK);
      #1;
      out_rdy = 1'b1;
      in_ena  = 1'b1;
      in_v    = ws2[0];
      @(negedge CLK);
      n_cmp++;
      if (out_ena !== 1'b1 || in_rdy !== 1'b1 || out_v !== exp) begin
         n_err++;
         $display("FAIL stall_release: out_ena=%b in_rdy=%b out_v=%h, required 1/1/%h", out_ena, in_rdy, out_v, exp);
      end
      @(posedge CLK);
      #1;
      in_ena = 1'b0;
      for (int i = 1; i < 4; i++) send_word(ws2[i]);
      tick(4);
      n_cmp++;
      if (msg_q.size() !== 2) begin
         n_err++;
         $display("FAIL stall_msg_count: got %0d messages, required 2", msg_q.size());
      end else begin
         n_cmp++;
         if (msg_q[0] !== exp || msg_q[1] !== exp2) begin
            n_err++;
            $display("FAIL stall_msgs: got %h / %h required %h / %h", msg_q[0], msg_q[1], exp, exp2);
         end
      end
   endtask

   task automatic check_stream(input string name, input int n_words);
      logic [31:0] grp[$];
      msg_t        exp_q[$];
      for (int i = 0; i < acc_q.size(); i++) begin
         grp.push_back(acc_q[i]);
         if (grp.size() == 4) begin
            exp_q.push_back(make_msg(grp));
            grp.delete();
         end
      end
      if (grp.size() > 0) exp_q.push_back(make_msg(grp));
      n_cmp++;
      if (acc_q.size() !== n_words || msg_q.size() !== exp_q.size()) begin
         n_err++;
         $display("FAIL %s_counts: accepted %0d messages %0d, required %0d / %0d", name, acc_q.size(), msg_q.size(), n_words, exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (msg_q[i] !== exp_q[i]) begin
               n_err++;
               $display("FAIL %s_msg%0d: got %h required %h", name, i, msg_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_logs();
      out_rdy = 1'b1;
      in_ena  = 1'b1;
      for (int i = 0; i < 12; i++) begin
         in_v = $urandom;
         @(posedge CLK);
         #1;
      end
      in_ena = 1'b0;
      tick(4);
      check_stream("b2b", 12);
   endtask

   task automatic test_random();
      clear_logs();
      rand_rdy = 1'b1;
      for (int i = 0; i < 62; i++) begin
         tick($urandom_range(0, 3));
         send_word($urandom);
      end
      rand_rdy = 1'b0;
      tick(2);
      out_rdy = 1'b1;
      tick(40);
      check_stream("random", 62);
   endtask

   task automatic test_reset_mid();
      logic [31:0] ws[$];
      msg_t        exp;
      clear_logs();
      for (int i = 0; i < 3; i++) send_word($urandom);
      nRST = 1'b0;
      #1;
      n_cmp++;
      if (in_rdy !== 1'b0 || out_ena !== 1'b0 || out_v !== '0) begin
         n_err++;
         $display("FAIL midreset_outputs: in_rdy=%b out_ena=%b out_v=%h, required 0/0/0", in_rdy, out_ena, out_v);
      end
      tick(2);
      nRST = 1'b1;
      clear_logs();
      tick(30);
      n_cmp++;
      if (msg_q.size() !== 0) begin
         n_err++;
         $display("FAIL midreset_silent: got %0d messages, required 0", msg_q.size());
      end
      for (int i = 0; i < 4; i++) ws.push_back($urandom);
      exp = make_msg(ws);
      for (int i = 0; i < 4; i++) send_word(ws[i]);
      tick(4);
      n_cmp++;
      if (msg_q.size() !== 1 || msg_q[0] !== exp) begin
         n_err++;
         $display("FAIL midreset_msg: got %0d messages first %h, required 1 of %h", msg_q.size(), (msg_q.size() > 0) ? msg_q[0] : '0, exp);
      end
   endtask

   task automatic test_no_timeout();
      logic [31:0] ws[$];
      msg_t        exp;
      for (int i = 0; i < 4; i++) ws.push_back($urandom);
      exp = make_msg(ws);
      z_msgs   = 0;
      z_in_ena = 1'b1;
      z_in_v   = ws[0];
      tick(1);
      z_in_ena = 1'b0;
      tick(1000);
      @(negedge CLK);
      n_cmp++;
      if (z_msgs !== 0 || z_in_rdy !== 1'b1) begin
         n_err++;
         $display("FAIL notimeout_idle: got %0d messages in_rdy=%b, required 0 / 1", z_msgs, z_in_rdy);
      end
      @(posedge CLK);
      #1;
      z_in_ena = 1'b1;
      for (int i = 1; i < 4; i++) begin
         z_in_v = ws[i];
         tick(1);
      end
      z_in_ena = 1'b0;
      tick(4);
      n_cmp++;
      if (z_msgs !== 1 || z_last !== exp) begin
         n_err++;
         $display("FAIL notimeout_msg: got %0d messages last %h, required 1 of %h", z_msgs, z_last, exp);
      end
   endtask

   initial begin
      test_reset();
      test_full();
      test_timeout();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_no_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
